output_module: RTL and testbench

// - Router output port stage; consumes fout_req_o/fout_resp_i of N_INPUTS input_datapath instances.
// - Drives one physical output link.
// - Wormhole arbitration per virtual channel: a head flit claims its VC at this output; the claim holds until the tail flit.
// - Packets on different VCs interleave flit-by-flit. Round-robin fairness between inputs.

---
 rtl/output_module.sv | 187 ++++++++++++++++++
 tb/tb_output_module.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_module.sv
// -----------------------------------------------------------------------------
// output_module -- router output port stage (plus the ravenoc_pkg it depends on)
//
// Merges the flit requests of N_INPUTS input datapaths onto one physical output
// link. Arbitration is wormhole per virtual channel: a HEAD flit claims its VC
// at this output and the claim holds until the matching TAIL flit. Packets on
// different VCs interleave flit by flit, and inputs share the link round-robin.
//
// Optional feature macro: OUTPUT_MODULE_ERR_EN
//   defined   : orphan BODY/TAIL flits (unlocked VC, or a VC owned by another
//               input) are discarded at lowest priority and raise a sticky err_o.
//   undefined : orphan flits are never granted; err_o is tied low.
//
// Ports
//   clk          in   1                     clock
//   arst         in   1                     asynchronous reset, active-low
//   fin_req_i    in   s_flit_req_t  [N]     per-input fdata / valid / vc_id
//   fin_resp_o   out  s_flit_resp_t [N]     per-input ready
//   fout_req_o   out  s_flit_req_t          flit presented on the output link
//   fout_resp_i  in   s_flit_resp_t         output link ready
//   err_o        out  1                     sticky protocol error
//
// Handshake: a flit moves across an interface on a clock edge where valid and
// ready are both high. Upstream never withdraws valid once raised, and ready
// never depends on anything downstream other than fout_resp_i.ready.
// -----------------------------------------------------------------------------
package ravenoc_pkg;
    localparam int N_VIRT_CHN = 2;
    localparam int FLIT_WIDTH = 16;
    localparam int VC_WIDTH   = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

    // Flit type lives in the two MSBs of fdata.
    localparam logic [1:0] FLIT_HEAD      = 2'b00;
    localparam logic [1:0] FLIT_BODY      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] fdata;
        logic                  valid;
        logic [VC_WIDTH-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;
endpackage

module output_module
    import ravenoc_pkg::*;
#(
    parameter int N_INPUTS = 5
) (
    input  logic         clk,
    input  logic         arst,
    input  s_flit_req_t  fin_req_i  [N_INPUTS],
    output s_flit_resp_t fin_resp_o [N_INPUTS],
    output s_flit_req_t  fout_req_o,
    input  s_flit_resp_t fout_resp_i,
    output logic         err_o
);

    localparam int IW = $clog2(N_INPUTS);

    logic [N_VIRT_CHN-1:0] r_lock_vld;
    logic [IW-1:0]         r_lock_own [N_VIRT_CHN];
    logic [IW-1:0]         r_rr_ptr;

    logic [N_INPUTS-1:0]   w_norm;      // eligible under normal wormhole rules
    logic                  w_gnt_vld;
    logic                  w_gnt_orph;  // grant went to an orphan (discard)
    logic [IW-1:0]         w_gnt_idx;
    logic [1:0]            w_gnt_type;
    logic [VC_WIDTH-1:0]   w_gnt_vc;
    logic                  w_xfer;

    // Position k of the round-robin scan, starting at base, modulo N_INPUTS.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_INPUTS) s = s - N_INPUTS;
        return IW'(s);
    endfunction

`ifdef OUTPUT_MODULE_ERR_EN
    logic [N_INPUTS-1:0]   w_orph;
`endif

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_cls
        logic [1:0]          w_type;
        logic [VC_WIDTH-1:0] w_vc;
        logic                w_is_head;
        logic                w_owned;

        assign w_type    = fin_req_i[gi].fdata[FLIT_WIDTH-1 -: 2];
        assign w_vc      = fin_req_i[gi].vc_id;
        assign w_is_head = (w_type == FLIT_HEAD) || (w_type == FLIT_HEAD_TAIL);
        assign w_owned   = r_lock_vld[w_vc] && (r_lock_own[w_vc] == IW'(gi));
        // HEAD needs a free VC; BODY/TAIL must continue the packet this input owns.
        assign w_norm[gi] = fin_req_i[gi].valid && (w_is_head ? !r_lock_vld[w_vc] : w_owned);
`ifdef OUTPUT_MODULE_ERR_EN
        assign w_orph[gi] = fin_req_i[gi].valid && !w_is_head && !w_owned;
`endif
    end

    // Round-robin pick: normal candidates first, orphans only if none exist.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_orph = 1'b0;
        w_gnt_idx  = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!w_gnt_vld && w_norm[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = rr_idx(r_rr_ptr, k);
            end
        end
`ifdef OUTPUT_MODULE_ERR_EN
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!w_gnt_vld && w_orph[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_orph = 1'b1;
                w_gnt_idx  = rr_idx(r_rr_ptr, k);
            end
        end
`endif
        // Nothing is granted while reset is held, even with upstream valid.
        if (!arst) begin
            w_gnt_vld  = 1'b0;
            w_gnt_orph = 1'b0;
        end
    end

    assign w_gnt_type = fin_req_i[w_gnt_idx].fdata[FLIT_WIDTH-1 -: 2];
    assign w_gnt_vc   = fin_req_i[w_gnt_idx].vc_id;
    assign w_xfer     = w_gnt_vld && !w_gnt_orph && fout_resp_i.ready;

    always_comb begin
        fout_req_o = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            fin_resp_o[i] = '0;
        end
        if (w_gnt_vld) begin
            if (w_gnt_orph) begin
                // Orphan is swallowed here; the link never sees it.
                fin_resp_o[w_gnt_idx].ready = 1'b1;
            end else begin
                fout_req_o                  = fin_req_i[w_gnt_idx];
                fin_resp_o[w_gnt_idx].ready = fout_resp_i.ready;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_lock_vld <= '0;
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                r_lock_own[v] <= '0;
            end
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (w_gnt_type == FLIT_HEAD) begin
                r_lock_vld[w_gnt_vc] <= 1'b1;
                r_lock_own[w_gnt_vc] <= w_gnt_idx;
            end else if (w_gnt_type == FLIT_TAIL) begin
                r_lock_vld[w_gnt_vc] <= 1'b0;
            end
            r_rr_ptr <= (w_gnt_idx == IW'(N_INPUTS - 1)) ? '0 : w_gnt_idx + IW'(1);
        end
    end

`ifdef OUTPUT_MODULE_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_err <= 1'b0;
        end else if (w_gnt_vld && w_gnt_orph) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_module.sv
// -----------------------------------------------------------------------------
// tb_output_module -- self-checking bench for output_module (N_INPUTS=4).
// Each input has a source queue of flits; the link side is checked by a
// scoreboard queue of expected {vc_id, fdata} words filled by each scenario.
// Scenario tasks run in phase "posedge + 1"; tick() samples at the negedge.
// Orphan handling depends on OUTPUT_MODULE_ERR_EN, mirrored here.
// -----------------------------------------------------------------------------
module tb_output_module;
    import ravenoc_pkg::*;

    localparam int NI = 4;
    localparam int EW = FLIT_WIDTH + VC_WIDTH;

    logic         clk;
    logic         arst;
    s_flit_req_t  fin_req  [NI];
    s_flit_resp_t fin_resp [NI];
    s_flit_req_t  fout_req;
    s_flit_resp_t fout_resp;
    logic         err;
    logic         link_rdy;

    assign fout_resp.ready = link_rdy;

    output_module #(.N_INPUTS(NI)) dut (
        .clk        (clk),
        .arst       (arst),
        .fin_req_i  (fin_req),
        .fin_resp_o (fin_resp),
        .fout_req_o (fout_req),
        .fout_resp_i(fout_resp),
        .err_o      (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    s_flit_req_t   src_q [NI][$];
    logic [EW-1:0] exp_q [$];
    int            obs_src [$];
    int            obs_cyc [$];
    logic [NI-1:0] snap;
    int            cyc;
    int            checks;
    int            errors;

    function automatic s_flit_req_t mk(input logic [1:0] t, input int vc, input int tag);
        s_flit_req_t f;
        f.fdata = {t, (FLIT_WIDTH-2)'(tag)};
        f.valid = 1'b1;
        f.vc_id = VC_WIDTH'(vc);
        return f;
    endfunction

    function automatic logic [EW-1:0] ex(input s_flit_req_t f);
        return {f.vc_id, f.fdata};
    endfunction

    function automatic bit src_pending();
        for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        for (int i = 0; i < NI; i++) begin
            fin_req[i] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    // One clock: scoreboard at the negedge, then advance sources after the edge.
    task automatic tick();
        int s;
        logic [EW-1:0] e;
        @(negedge clk);
        s = -1;
        for (int i = 0; i < NI; i++) begin
            snap[i] = arst && fin_resp[i].ready && fin_req[i].valid;
            if (fin_resp[i].ready) s = i;
        end
        if (arst && fout_req.valid && link_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL link_unexpected: got %h from in%0d, none expected", {fout_req.vc_id, fout_req.fdata}, s);
            end else begin
                e = exp_q.pop_front();
                if ({fout_req.vc_id, fout_req.fdata} !== e) begin
                    errors++;
                    $display("FAIL link_flit: got %h from in%0d, required %h", {fout_req.vc_id, fout_req.fdata}, s, e);
                end
            end
            obs_src.push_back(s);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (snap[i]) void'(src_q[i].pop_front());
        end
        apply_inputs();
    endtask

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src_pending()) begin
            errors++;
            $display("FAIL %s_drain: %0d flits still expected after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
            for (int i = 0; i < NI; i++) src_q[i].delete();
            apply_inputs();
        end
    endtask

    task automatic do_reset();
        arst = 1'b0;
        #2;
        arst = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_src.delete(); obs_cyc.delete();
        for (int i = 0; i < NI; i++) src_q[i].push_back(mk(FLIT_HEAD_TAIL, i % 2, 16 + i));
        for (int i = 0; i < NI; i++) exp_q.push_back(ex(mk(FLIT_HEAD_TAIL, i % 2, 16 + i)));
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fout_req !== '0) begin errors++; $display("FAIL reset_fout: got %h, required 0", fout_req); end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (fin_resp[i].ready !== 1'b0) begin errors++; $display("FAIL reset_ready%0d: got %b, required 0", i, fin_resp[i].ready); end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        arst = 1'b1;
        #1;
        checks++;
        if (fin_resp[0].ready !== 1'b1) begin errors++; $display("FAIL reset_first_grant: in0 ready %b, required 1", fin_resp[0].ready); end
        run_drain("reset", 20);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (obs_src.size() <= k || obs_src[k] !== k) begin
                errors++; $display("FAIL reset_rr_order[%0d]: got in%0d, required in%0d", k, (obs_src.size() > k) ? obs_src[k] : -1, k);
            end
        end
    endtask

    task automatic test_vc_interleave();
        logic [1:0] ty [3];
        ty = '{FLIT_HEAD, FLIT_BODY, FLIT_TAIL};
        obs_src.delete(); obs_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            src_q[0].push_back(mk(ty[k], 0, 256 + k));
            src_q[3].push_back(mk(ty[k], 1, 304 + k));
            exp_q.push_back(ex(mk(ty[k], 0, 256 + k)));
            exp_q.push_back(ex(mk(ty[k], 1, 304 + k)));
        end
        apply_inputs();
        run_drain("interleave", 20);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs_src.size() <= k || obs_src[k] !== ((k % 2 == 0) ? 0 : 3)) begin
                errors++; $display("FAIL interleave_src[%0d]: got in%0d, required in%0d", k, (obs_src.size() > k) ? obs_src[k] : -1, (k % 2 == 0) ? 0 : 3);
            end
        end
        checks++;
        if (obs_cyc.size() != 6 || obs_cyc[5] - obs_cyc[0] != 5) begin
            errors++; $display("FAIL interleave_gapless: %0d transfers, span not 5 cycles", obs_cyc.size());
        end
    endtask

    task automatic test_wormhole();
        int exp_src [6];
        exp_src = '{1, 1, 1, 1, 2, 2};
        obs_src.delete(); obs_cyc.delete();
        src_q[1].push_back(mk(FLIT_HEAD, 0, 512));
        src_q[1].push_back(mk(FLIT_BODY, 0, 513));
        src_q[1].push_back(mk(FLIT_BODY, 0, 514));
        src_q[1].push_back(mk(FLIT_TAIL, 0, 515));
        src_q[2].push_back(mk(FLIT_HEAD, 0, 544));
        src_q[2].push_back(mk(FLIT_TAIL, 0, 545));
        for (int k = 0; k < 4; k++) exp_q.push_back(ex(src_q[1][k]));
        for (int k = 0; k < 2; k++) exp_q.push_back(ex(src_q[2][k]));
        apply_inputs();
        run_drain("wormhole", 20);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs_src.size() <= k || obs_src[k] !== exp_src[k]) begin
                errors++; $display("FAIL wormhole_src[%0d]: got in%0d, required in%0d", k, (obs_src.size() > k) ? obs_src[k] : -1, exp_src[k]);
            end
        end
        checks++;
        if (obs_cyc.size() != 6 || obs_cyc[4] - obs_cyc[3] != 1) begin
            errors++; $display("FAIL wormhole_head_after_tail: in2 head not one cycle after in1 tail (%0d transfers)", obs_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        s_flit_req_t held;
        int n;
        obs_src.delete(); obs_cyc.delete();
        src_q[1].push_back(mk(FLIT_HEAD, 1, 768));
        for (int k = 1; k < 4; k++) src_q[1].push_back(mk(FLIT_BODY, 1, 768 + k));
        src_q[1].push_back(mk(FLIT_TAIL, 1, 772));
        for (int k = 0; k < 5; k++) exp_q.push_back(ex(src_q[1][k]));
        held = src_q[1][2];
        apply_inputs();
        n = 0;
        while (obs_src.size() < 2 && n < 20) begin tick(); n++; end
        link_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (fout_req !== held) begin errors++; $display("FAIL bp_hold[%0d]: got %h, required %h", c, fout_req, held); end
            checks++;
            if (fin_resp[1].ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b, required 0", c, fin_resp[1].ready); end
            tick();
        end
        link_rdy = 1'b1;
        run_drain("backpressure", 20);
        checks++;
        if (obs_src.size() != 5) begin errors++; $display("FAIL bp_count: got %0d link flits, required 5", obs_src.size()); end
    endtask

    task automatic test_reset_mid_packet();
        src_q[0].push_back(mk(FLIT_HEAD, 0, 1024));
        exp_q.push_back(ex(src_q[0][0]));
        apply_inputs();
        run_drain("midpkt_head", 10);
        do_reset();
        // VC0 was claimed by in0; a fresh head from in1 must get through.
        src_q[1].push_back(mk(FLIT_HEAD_TAIL, 0, 1040));
        exp_q.push_back(ex(src_q[1][0]));
        apply_inputs();
        run_drain("midpkt_after_reset", 10);
    endtask

    task automatic test_fairness();
        int cnt [NI];
        int bad;
        do_reset();
        obs_src.delete(); obs_cyc.delete();
        for (int k = 0; k < 40; k++) begin
            src_q[k % NI].push_back(mk(FLIT_HEAD_TAIL, (k % NI) % 2, 1280 + k));
            exp_q.push_back(ex(mk(FLIT_HEAD_TAIL, (k % NI) % 2, 1280 + k)));
        end
        apply_inputs();
        run_drain("fairness", 60);
        bad = 0;
        for (int i = 0; i < NI; i++) cnt[i] = 0;
        for (int k = 0; k < obs_src.size(); k++) begin
            if (obs_src[k] >= 0 && obs_src[k] < NI) cnt[obs_src[k]]++;
            if (obs_src[k] !== k % NI) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fair_order: %0d grants out of rr order, required 0", bad); end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (cnt[i] != 10) begin errors++; $display("FAIL fair_share%0d: got %0d grants, required 10", i, cnt[i]); end
        end
        checks++;
        if (obs_cyc.size() != 40 || obs_cyc[39] - obs_cyc[0] != 39) begin
            errors++; $display("FAIL fair_gapless: %0d transfers, span not 39 cycles", obs_cyc.size());
        end
    endtask

    task automatic test_orphan();
        src_q[2].push_back(mk(FLIT_BODY, 1, 1536));
        apply_inputs();
        #1;
`ifdef OUTPUT_MODULE_ERR_EN
        checks++;
        if (fin_resp[2].ready !== 1'b1) begin errors++; $display("FAIL orphan_ready: got %b, required 1", fin_resp[2].ready); end
        checks++;
        if (fout_req.valid !== 1'b0) begin errors++; $display("FAIL orphan_fout_valid: got %b, required 0", fout_req.valid); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL orphan_err_before: got %b, required 0", err); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL orphan_err_set: got %b, required 1", err); end
        checks++;
        if (src_q[2].size() != 0) begin errors++; $display("FAIL orphan_consumed: %0d flits left on in2, required 0", src_q[2].size()); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky: got %b, required 1", err); end
`else
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (fin_resp[2].ready !== 1'b0 || fout_req.valid !== 1'b0) begin
                errors++; $display("FAIL orphan_stall[%0d]: ready %b fout valid %b, required 0 0", c, fin_resp[2].ready, fout_req.valid);
            end
            tick();
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL orphan_err_tied: got %b, required 0", err); end
        src_q[2].delete();
        apply_inputs();
`endif
    endtask

    // ---------------- main sequence / final report ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        snap     = '0;
        arst     = 1'b0;
        link_rdy = 1'b1;
        for (int i = 0; i < NI; i++) fin_req[i] = '0;

        test_reset();
        test_vc_interleave();
        test_wormhole();
        test_backpressure();
        test_reset_mid_packet();
        test_fairness();
        test_orphan();

        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d expected flits never seen, required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait above is ever left unbounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
